// File: rtl/ex_muldiv_stage.sv
// EX-stage operand forwarding plus an iterative multiply/divide unit owning HI/LO.
// One radix-2 step per cycle; HI/LO only change on the last step or on MTHI/MTLO.
module ex_muldiv_stage #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] sa,
  input  logic            alusrc_a,
  input  logic            alusrc_b,
  input  logic            regdst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mem_we,
  input  logic [AW-1:0]   mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic [2:0]      md_op,
  input  logic [1:0]      mf_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_y,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] store_data,
  output logic [AW-1:0]   wr_addr,
  output logic            stall,
  output logic            md_busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [2:0] OpMult = 3'b001, OpMultu = 3'b010, OpDiv = 3'b011,
                         OpDivu = 3'b100, OpMthi = 3'b101, OpMtlo = 3'b110;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdState_t;
  mdState_t state, nextState;

  logic [XLEN-1:0] fwdRs, fwdRt;
  logic [XLEN-1:0] hiReg, loReg;
  logic [XLEN-1:0] accHi, accLo, opB, dividend;
  logic            isDiv, negRes, negRem, divZero;
  logic [CW-1:0]   cnt;
  logic            mdStart, mdActive, mfRead, lastStep, isSigned, aNeg, bNeg;

  // MEM is the younger producer, so it overrides WB
  always_comb begin
    fwdRs = rs_data;
    fwdRt = rt_data;
    if (wb_we && wb_addr != '0 && wb_addr == rs_addr) fwdRs = wb_data;
    if (mem_we && mem_addr != '0 && mem_addr == rs_addr) fwdRs = mem_data;
    if (wb_we && wb_addr != '0 && wb_addr == rt_addr) fwdRt = wb_data;
    if (mem_we && mem_addr != '0 && mem_addr == rt_addr) fwdRt = mem_data;
  end

  assign alu_a      = alusrc_a ? sa : fwdRs;
  assign alu_b      = alusrc_b ? imm : fwdRt;
  assign store_data = fwdRt;
  assign wr_addr    = regdst ? rd_addr : rt_addr;

  always_comb begin
    case (mf_sel)
      2'b01:   ex_result = hiReg;
      2'b10:   ex_result = loReg;
      default: ex_result = alu_y;
    endcase
  end

  assign mdActive = (md_op != 3'b000) && (md_op != 3'b111);
  assign mfRead   = (mf_sel == 2'b01) || (mf_sel == 2'b10);
  assign stall    = ex_valid && md_busy && (mdActive || mfRead);
  assign mdStart  = ex_valid && (state == IDLE) &&
                    (md_op == OpMult || md_op == OpMultu || md_op == OpDiv || md_op == OpDivu);
  assign lastStep = (state == RUN) && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (mdStart) nextState = RUN;
      RUN:     if (lastStep) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    md_busy = (state == RUN);
  end

  // Both algorithms work on magnitudes; signs are reapplied on the last step
  assign isSigned = (md_op == OpMult) || (md_op == OpDiv);
  assign aNeg     = isSigned && fwdRs[XLEN-1];
  assign bNeg     = isSigned && fwdRt[XLEN-1];

  logic [XLEN:0]     mulSum, divShift, divTrial;
  logic [XLEN-1:0]   stepHi, stepLo, quo, rem, finHi, finLo;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    divShift = {accHi, accLo[XLEN-1]};
    divTrial = divShift - {1'b0, opB};
    if (isDiv) begin
      if (!divTrial[XLEN]) begin
        stepHi = divTrial[XLEN-1:0];
        stepLo = {accLo[XLEN-2:0], 1'b1};
      end else begin
        stepHi = divShift[XLEN-1:0];
        stepLo = {accLo[XLEN-2:0], 1'b0};
      end
    end else begin
      stepHi = mulSum[XLEN:1];
      stepLo = {mulSum[0], accLo[XLEN-1:1]};
    end
    prod = negRes ? -{stepHi, stepLo} : {stepHi, stepLo};
    quo  = negRes ? -stepLo : stepLo;
    rem  = negRem ? -stepHi : stepHi;
    if (!isDiv) begin
      finHi = prod[2*XLEN-1:XLEN];
      finLo = prod[XLEN-1:0];
    end else if (divZero) begin
      finHi = dividend;
      finLo = '1;
    end else begin
      finHi = rem;
      finLo = quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      accHi    <= '0;
      accLo    <= '0;
      opB      <= '0;
      dividend <= '0;
      isDiv    <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      divZero  <= 1'b0;
    end else if (mdStart) begin
      cnt      <= '0;
      accHi    <= '0;
      accLo    <= aNeg ? -fwdRs : fwdRs;
      opB      <= bNeg ? -fwdRt : fwdRt;
      dividend <= fwdRs;
      isDiv    <= (md_op == OpDiv) || (md_op == OpDivu);
      negRes   <= aNeg ^ bNeg;
      negRem   <= aNeg;
      divZero  <= (fwdRt == '0);
    end else if (state == RUN) begin
      cnt   <= lastStep ? '0 : cnt + CW'(1);
      accHi <= stepHi;
      accLo <= stepLo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (lastStep) begin
      hiReg <= finHi;
      loReg <= finLo;
    end else if (ex_valid && !stall) begin
      if (md_op == OpMthi) hiReg <= fwdRs;
      if (md_op == OpMtlo) loReg <= fwdRs;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed + randomized bench for ex_muldiv_stage against an arithmetic reference model.
module tb_ex_muldiv_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid, alusrc_a, alusrc_b, regdst, wb_we, mem_we, stall, md_busy;
  logic [4:0]  rs_addr, rt_addr, rd_addr, wb_addr, mem_addr, wr_addr;
  logic [31:0] rs_data, rt_data, imm, sa, wb_data, mem_data, alu_a, alu_b, alu_y;
  logic [31:0] ex_result, store_data;
  logic [2:0]  md_op;
  logic [1:0]  mf_sel;

  logic        v16, busy16, stall16;
  logic [2:0]  op16;
  logic [1:0]  mf16;
  logic [15:0] rs16, rt16, res16, aluA16, aluB16, sd16;
  logic [4:0]  wa16;

  int total = 0, bad = 0;

  ex_muldiv_stage #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .sa(sa),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .regdst(regdst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .md_op(md_op), .mf_sel(mf_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .ex_result(ex_result), .store_data(store_data), .wr_addr(wr_addr),
    .stall(stall), .md_busy(md_busy));

  ex_muldiv_stage #(.XLEN(16), .AW(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .ex_valid(v16),
    .rs_addr(5'd1), .rt_addr(5'd2), .rd_addr(5'd3),
    .rs_data(rs16), .rt_data(rt16), .imm(16'd0), .sa(16'd0),
    .alusrc_a(1'b0), .alusrc_b(1'b0), .regdst(1'b0),
    .wb_we(1'b0), .wb_addr(5'd0), .wb_data(16'd0),
    .mem_we(1'b0), .mem_addr(5'd0), .mem_data(16'd0),
    .md_op(op16), .mf_sel(mf16), .alu_a(aluA16), .alu_b(aluB16), .alu_y(16'h1234),
    .ex_result(res16), .store_data(sd16), .wr_addr(wa16),
    .stall(stall16), .md_busy(busy16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] refMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sA, sB;
    longint sp;
    sA = a;
    sB = b;
    case (op)
      3'd1: begin sp = longint'(sA) * longint'(sB); return 64'(sp); end
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
        return {32'(sA % sB), 32'(sA / sB)};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwdRef(input logic [4:0] ad, input logic [31:0] rf,
      input logic mwe, input logic [4:0] ma, input logic [31:0] md,
      input logic wwe, input logic [4:0] wa, input logic [31:0] wd);
    if (mwe && ma != 0 && ma == ad) return md;
    if (wwe && wa != 0 && wa == ad) return wd;
    return rf;
  endfunction

  task automatic readHiLo(output logic [31:0] hi, output logic [31:0] lo);
    mf_sel = 2'b01; #1 hi = ex_result;
    mf_sel = 2'b10; #1 lo = ex_result;
    mf_sel = 2'b00; #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    ex_valid = 1'b1; md_op = op; rs_addr = 5'd1; rt_addr = 5'd2;
    rs_data = a; rt_data = b; mem_we = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0; md_op = 3'd0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (md_busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    logic [31:0] hi, lo, a, b, expA, expB;
    logic [63:0] exp;
    logic [2:0]  op;
    int n;

    ex_valid = 0; alusrc_a = 0; alusrc_b = 0; regdst = 0; wb_we = 0; mem_we = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; wb_addr = 0; mem_addr = 0;
    rs_data = 0; rt_data = 0; imm = 0; sa = 0; wb_data = 0; mem_data = 0;
    alu_y = 32'hA5A5_0001; md_op = 0; mf_sel = 0;
    v16 = 0; op16 = 0; mf16 = 0; rs16 = 0; rt16 = 0;

    // reset state
    #12;
    ex_valid = 1; md_op = 3'd1; mf_sel = 2'b10; #1;
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    ex_valid = 0; md_op = 0;
    readHiLo(hi, lo);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("alu_pass", 64'(ex_result), 64'hA5A5_0001);
    @(negedge clk); rst_n = 1;

    // forwarding priority
    rs_addr = 3; rs_data = 32'd1; mem_we = 1; mem_addr = 3; mem_data = 5;
    wb_we = 1; wb_addr = 3; wb_data = 9; #1;
    chk("fwd_mem", 64'(alu_a), 64'd5);
    mem_we = 0; #1;
    chk("fwd_wb", 64'(alu_a), 64'd9);
    rs_addr = 0; rs_data = 32'h77; mem_we = 1; mem_addr = 0; wb_addr = 0; #1;
    chk("fwd_r0", 64'(alu_a), 64'h77);
    for (int i = 0; i < 12; i++) begin
      rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
      rd_addr = 5'($urandom_range(0, 31));
      mem_addr = 5'($urandom_range(0, 3)); wb_addr = 5'($urandom_range(0, 3));
      mem_we = 1'($urandom); wb_we = 1'($urandom);
      alusrc_a = 1'($urandom); alusrc_b = 1'($urandom); regdst = 1'($urandom);
      rs_data = $urandom; rt_data = $urandom; mem_data = $urandom; wb_data = $urandom;
      imm = $urandom; sa = $urandom; #1;
      expA = fwdRef(rs_addr, rs_data, mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data);
      expB = fwdRef(rt_addr, rt_data, mem_we, mem_addr, mem_data, wb_we, wb_addr, wb_data);
      chk($sformatf("rnd_alu_a_%0d", i), 64'(alu_a), 64'(alusrc_a ? sa : expA));
      chk($sformatf("rnd_alu_b_%0d", i), 64'(alu_b), 64'(alusrc_b ? imm : expB));
      chk($sformatf("rnd_store_%0d", i), 64'(store_data), 64'(expB));
      chk($sformatf("rnd_wraddr_%0d", i), 64'(wr_addr), 64'(regdst ? rd_addr : rt_addr));
    end
    alusrc_a = 0; alusrc_b = 0; regdst = 0; mem_we = 0; wb_we = 0;

    // MULT -3 x 7, HI/LO held until the final step
    issue(3'd1, 32'hFFFFFFFD, 32'd7);
    chk("mult_busy_start", 64'(md_busy), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    readHiLo(hi, lo);
    chk("mult_mid_hi", 64'(hi), 64'd0);
    chk("mult_mid_lo", 64'(lo), 64'd0);
    waitDone(n);
    chk("mult_cycles", 64'(n + 10), 64'd32);
    readHiLo(hi, lo);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFEB);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    waitDone(n);
    readHiLo(hi, lo);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    issue(3'd4, 32'd7, 32'd0);
    waitDone(n);
    readHiLo(hi, lo);
    chk("divu0_lo", 64'(lo), 64'hFFFFFFFF);
    chk("divu0_hi", 64'(hi), 64'd7);

    // MFLO right behind MULTU stalls until the product lands
    issue(3'd2, 32'd6, 32'd7);
    ex_valid = 1; mf_sel = 2'b10; #1;
    chk("mflo_stall", 64'(stall), 64'd1);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mflo_stall_cycles", 64'(n), 64'd32);
    chk("mflo_result", 64'(ex_result), 64'd42);
    ex_valid = 0; mf_sel = 0;

    // a stalled DIVU starts on the first idle cycle
    issue(3'd2, 32'd3, 32'd5);
    ex_valid = 1; md_op = 3'd4; rs_data = 32'd100; rt_data = 32'd7;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stalled_op_idle", 64'(md_busy), 64'd0);
    @(posedge clk); #1;
    ex_valid = 0; md_op = 0;
    chk("stalled_op_start", 64'(md_busy), 64'd1);
    waitDone(n);
    readHiLo(hi, lo);
    chk("stalled_op_lo", 64'(lo), 64'd14);
    chk("stalled_op_hi", 64'(hi), 64'd2);

    // MTHI / MTLO, and no write without ex_valid
    issue(3'd5, 32'hDEAD0001, 32'd0);
    issue(3'd6, 32'hBEEF0002, 32'd0);
    md_op = 3'd5; rs_data = 32'h12345678;
    @(posedge clk); #1;
    md_op = 0;
    readHiLo(hi, lo);
    chk("mthi", 64'(hi), 64'hDEAD0001);
    chk("mtlo", 64'(lo), 64'hBEEF0002);

    // randomized operations against the reference model
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom; b = $urandom;
      if (i % 3 == 1) begin a = $urandom_range(0, 500); b = $urandom_range(1, 20); end
      if (i % 4 == 2) a = -a;
      if (i % 5 == 0) b = 0;
      if (i % 7 == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      exp = refMd(op, a, b);
      issue(op, a, b);
      waitDone(n);
      chk($sformatf("rnd_cycles_%0d", i), 64'(n), 64'd32);
      readHiLo(hi, lo);
      chk($sformatf("rnd_op%0d_%0h_%0h", op, a, b), {hi, lo}, exp);
    end

    // reset during RUN cycle 10
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    ex_valid = 1; md_op = 3'd1; rst_n = 0; #1;
    chk("midrst_busy", 64'(md_busy), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    ex_valid = 0; md_op = 0;
    readHiLo(hi, lo);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1;
    issue(3'd4, 32'd100, 32'd7);
    waitDone(n);
    readHiLo(hi, lo);
    chk("postrst_lo", 64'(lo), 64'd14);
    chk("postrst_hi", 64'(hi), 64'd2);

    // XLEN=16 build
    @(posedge clk); #1;
    v16 = 1; op16 = 3'd2; rs16 = 16'hFFFF; rt16 = 16'hFFFF;
    @(posedge clk); #1;
    v16 = 0; op16 = 0;
    n = 0;
    while (busy16 === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("x16_cycles", 64'(n), 64'd16);
    mf16 = 2'b01; #1;
    chk("x16_hi", 64'(res16), 64'hFFFE);
    mf16 = 2'b10; #1;
    chk("x16_lo", 64'(res16), 64'h0001);
    mf16 = 2'b00; #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_stage.md
EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width (>=8, even).
REQ-002 Parameter AW, default 5, register address width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ex_valid  in  1  instruction in EX is valid.
REQ-006 rs_addr, rt_addr, rd_addr  in  AW  source/destination addresses.
REQ-007 rs_data, rt_data  in  XLEN  register-file read data.
REQ-008 imm, sa  in  XLEN  extended immediate, shift amount.
REQ-009 alusrc_a, alusrc_b, regdst  in  1  select sa / imm / rd_addr when 1.
REQ-010 wb_we, mem_we  in  1; wb_addr, mem_addr  in  AW; wb_data, mem_data  in  XLEN  forwarding sources.
REQ-011 md_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
REQ-012 mf_sel  in  2  00 ALU result, 01 MFHI, 10 MFLO, 11 treated as 00.
REQ-013 alu_a, alu_b  out  XLEN  operands to external ALU; alu_y  in  XLEN  ALU result.
REQ-014 ex_result  out  XLEN; store_data  out  XLEN; wr_addr  out  AW.
REQ-015 stall  out  1  hold IF/ID/EX, bubble into MEM; md_busy  out  1.

Function
REQ-016 Forwarding SHALL prefer MEM (mem_we, mem_addr!=0, match) over WB (wb_we, wb_addr!=0, match) over register file, independently for rs and rt.
REQ-017 alu_a = alusrc_a ? sa : fwd_rs; alu_b = alusrc_b ? imm : fwd_rt; store_data = fwd_rt; wr_addr = regdst ? rd_addr : rt_addr; all combinational.
REQ-018 ex_result SHALL be alu_y, HI or LO per mf_sel, combinational.
REQ-019 FSM states IDLE, RUN; IDLE->RUN on start; RUN->IDLE after XLEN RUN cycles; md_busy = (state==RUN).
REQ-020 start = ex_valid && state==IDLE && md_op in {001..100}; operands latched from fwd_rs/fwd_rt at start edge.
REQ-021 Multiply: radix-2 shift-add, one bit per cycle; HI:LO = 2*XLEN-bit product, signed for MULT.
REQ-022 Divide: radix-2 restoring; LO = quotient, HI = remainder; signed via magnitudes, remainder sign = dividend sign.
REQ-023 Divide by zero: LO = all ones, HI = dividend; signed overflow (MIN / -1): LO = MIN, HI = 0.
REQ-024 HI/LO SHALL update only on the final RUN edge (XLEN edges after start edge); earlier values visible until then.
REQ-025 stall = ex_valid && md_busy && (md_op!=none || mf_sel in {01,10}); stall SHALL be 0 otherwise, combinational.
REQ-026 A stalled md_op SHALL start on the first IDLE cycle; a stalled MFHI/MFLO SHALL read the new HI/LO.
REQ-027 MTHI/MTLO when not stalled SHALL write fwd_rs to HI/LO at the edge; no effect when ex_valid=0.
REQ-028 ex_valid deasserting (flush) during RUN SHALL NOT abort the operation.
REQ-029 Counter SHALL be ceil(log2(XLEN+1)) bits, no wrap beyond XLEN.

Reset
REQ-030 rst_n low SHALL force state IDLE, counter 0, HI=0, LO=0, operand/accumulator registers 0, md_busy=0, immediately and mid-operation; stall=0 while in reset.
REQ-031 First operation after rst_n rises SHALL start on the next qualifying edge.

Verification
REQ-032 Forward priority: mem and wb both write r3, rs_addr=3, mem_data=5, wb_data=9 -> alu_a=5; mem_addr=0 with r0 -> register-file value.
REQ-033 MULT -3 x 7 (XLEN=32) -> md_busy 32 cycles, then HI=FFFFFFFF, LO=FFFFFFEB.
REQ-034 DIV -7 / 2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7/0 -> LO=FFFFFFFF, HI=7.
REQ-035 MFLO issued 1 cycle after MULTU 6x7 -> stall high until completion, then ex_result=42, stall=0.
REQ-036 rst_n low at RUN cycle 10 -> md_busy=0, HI=LO=0 at once; new DIVU 100/7 after reset -> LO=14, HI=2.
REQ-037 XLEN=16 build: MULTU FFFF x FFFF -> HI=FFFE, LO=0001 after 16 cycles.
